fifo_sync_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 28 ++
 rtl/fifo_sync_param.sv | 119 +++++++++++
 tb/tb_fifo_sync_param.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock parametrised FIFO.
// Read-mode selectors and a width helper that never returns zero.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port and an
// asynchronous read index. Contents are deliberately not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR  = clog2_safe(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky
// error flags and a registered or first-word-fall-through read port.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = FIFO_MODE_STD,
  localparam int ADDR     = clog2_safe(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  input  logic             pull,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ADDR:0] DEPTH_C = DEPTH[ADDR:0];
  localparam logic [ADDR:0] AF_C    = AF_THRESH[ADDR:0];
  localparam logic [ADDR:0] AE_C    = AE_THRESH[ADDR:0];
  localparam logic [ADDR:0] ONE_C   = {{ADDR{1'b0}}, 1'b1};

  logic [ADDR:0]    wptr_q, wptr_d;
  logic [ADDR:0]    rptr_q, rptr_d;
  logic [ADDR:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             wen, ren;
  logic             mem_we;
  logic [WIDTH-1:0] rdata;

  assign full         = (cnt_q == DEPTH_C);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    wen    = push & ~full;
    ren    = pull & ~empty;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    if (wen) begin
      wptr_d = wptr_q + ONE_C;
    end
    if (ren) begin
      rptr_d = rptr_q + ONE_C;
      dout_d = rdata;
      dv_d   = 1'b1;
    end
    unique case ({wen, ren})
      2'b10:   cnt_d = cnt_q + ONE_C;
      2'b01:   cnt_d = cnt_q - ONE_C;
      default: cnt_d = cnt_q;
    endcase
    // a new error in the same cycle as clr_err keeps the flag set
    ovf_d = (push & full) | (ovf_q & ~clr_err);
    unf_d = (pull & empty) | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
    end
  end

  assign mem_we = wen & ~rst;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_q[ADDR-1:0]),
    .wdata (din),
    .raddr (rptr_q[ADDR-1:0]),
    .rdata (rdata)
  );

  // FWFT masks the head slot while empty so stale RAM never leaks out
  assign dout = (FWFT == FIFO_MODE_FWFT) ? (empty ? '0 : rdata) : dout_q;
  assign dout_valid = (FWFT == FIFO_MODE_FWFT) ? ~empty : dv_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed and random checks of fifo_sync_param against a queue model.
// Three instances share stimulus; one is observed per section.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pull = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] dout_a, dout_b, dout_f;
  logic       dv_a, dv_b, dv_f;
  logic       full_a, full_b, full_f;
  logic       empty_a, empty_b, empty_f;
  logic       af_a, af_b, af_f;
  logic       ae_a, ae_b, ae_f;
  logic [4:0] cnt_a, cnt_f;
  logic [2:0] cnt_b;
  logic       ovf_a, ovf_b, ovf_f;
  logic       unf_a, unf_b, unf_f;

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst), .din(din), .push(push), .pull(pull),
    .clr_err(clr_err), .dout(dout_a), .dout_valid(dv_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(cnt_a), .overflow(ovf_a),
    .underflow(unf_a)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3),
                    .AE_THRESH(1), .FWFT(0)) dut_b (
    .clk(clk), .rst(rst), .din(din), .push(push), .pull(pull),
    .clr_err(clr_err), .dout(dout_b), .dout_valid(dv_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(cnt_b), .overflow(ovf_b),
    .underflow(unf_b)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .din(din), .push(push), .pull(pull),
    .clr_err(clr_err), .dout(dout_f), .dout_valid(dv_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(cnt_f), .overflow(ovf_f),
    .underflow(unf_f)
  );

  int sel = 0;
  logic [7:0]  o_dout;
  logic        o_dv, o_full, o_empty, o_af, o_ae, o_ovf, o_unf;
  logic [31:0] o_cnt;

  always_comb begin
    o_dout = dout_a; o_dv = dv_a; o_full = full_a; o_empty = empty_a;
    o_af = af_a; o_ae = ae_a; o_ovf = ovf_a; o_unf = unf_a;
    o_cnt = 32'(cnt_a);
    if (sel == 1) begin
      o_dout = dout_b; o_dv = dv_b; o_full = full_b; o_empty = empty_b;
      o_af = af_b; o_ae = ae_b; o_ovf = ovf_b; o_unf = unf_b;
      o_cnt = 32'(cnt_b);
    end else if (sel == 2) begin
      o_dout = dout_f; o_dv = dv_f; o_full = full_f; o_empty = empty_f;
      o_af = af_f; o_ae = ae_f; o_ovf = ovf_f; o_unf = unf_f;
      o_cnt = 32'(cnt_f);
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  int         m_depth = 16;
  int         m_af = 12;
  int         m_ae = 4;
  bit         m_fwft = 0;
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_dout = '0;
  bit         m_dv = 0;
  bit         m_ovf = 0;
  bit         m_unf = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    int n;
    n = m_q.size();
    chk("count", o_cnt, 32'(n));
    chk("full", 32'(o_full), 32'(n == m_depth));
    chk("empty", 32'(o_empty), 32'(n == 0));
    chk("almost_full", 32'(o_af), 32'(n >= m_af));
    chk("almost_empty", 32'(o_ae), 32'(n <= m_ae));
    chk("overflow", 32'(o_ovf), 32'(m_ovf));
    chk("underflow", 32'(o_unf), 32'(m_unf));
    if (m_fwft) begin
      chk("dout_valid", 32'(o_dv), 32'(n != 0));
      chk("dout", 32'(o_dout), (n != 0) ? 32'(m_q[0]) : 32'h0);
    end else begin
      chk("dout_valid", 32'(o_dv), 32'(m_dv));
      if (m_dv && exp_q.size() != 0) m_dout = exp_q.pop_front();
      chk("dout", 32'(o_dout), 32'(m_dout));
    end
  endtask

  task automatic cyc(input logic p, input logic l, input logic [7:0] d,
                     input logic c);
    int  n;
    bit  wen, ren;
    logic [7:0] tmp;
    push = p; pull = l; din = d; clr_err = c;
    n = m_q.size();
    wen = p && (n < m_depth);
    ren = l && (n > 0);
    @(posedge clk); #1;
    if (p && n == m_depth) m_ovf = 1; else if (c) m_ovf = 0;
    if (l && n == 0) m_unf = 1; else if (c) m_unf = 0;
    m_dv = ren && !m_fwft;
    if (ren) begin
      tmp = m_q.pop_front();
      if (!m_fwft) exp_q.push_back(tmp);
    end
    if (wen) m_q.push_back(d);
    push = 0; pull = 0; clr_err = 0;
    chk_all();
  endtask

  task automatic do_reset(input int ncyc, input logic p);
    rst = 1; push = p; din = 8'hEE;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 0; push = 0;
    m_q.delete(); exp_q.delete();
    m_dout = '0; m_dv = 0; m_ovf = 0; m_unf = 0;
    chk_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0; m_depth = 16; m_af = 12; m_ae = 4; m_fwft = 0;
    do_reset(2, 1'b1);

    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i), 0);
    cyc(1, 0, 8'hFF, 0);

    for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    for (int i = 0; i < 5; i++) cyc(1, 0, 8'h10 + 8'(i), 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h20 + 8'(i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'h00, 0);
    cyc(1, 1, 8'h3C, 0);
    for (int i = 0; i < 15; i++) cyc(1, 0, 8'h40 + 8'(i), 0);
    cyc(1, 1, 8'h77, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'h00, 0);

    sel = 1; m_depth = 4; m_af = 3; m_ae = 1; m_fwft = 0;
    do_reset(1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)), 1'($urandom_range(0, 15) == 0));
    end

    sel = 2; m_depth = 16; m_af = 12; m_ae = 4; m_fwft = 1;
    do_reset(1, 1'b0);
    cyc(1, 0, 8'hA5, 0);
    cyc(0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'hB0 + 8'(i), 0);
    cyc(0, 1, 8'h00, 0);
    cyc(1, 1, 8'hC0, 0);
    cyc(1, 0, 8'hC1, 0);
    do_reset(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
